// File: rtl/hazard_stall_unit.sv
// Load-use stall / redirect flush controller for the 5-stage RV32I pipeline.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned CNT_W             = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [31:0]      inst_ID,
   input  logic             valid_ID,
   input  logic [31:0]      inst_EX,
   input  logic             valid_EX,
   input  logic             redirect_EX,
   output logic             stall_PC,
   output logic             stall_IFID,
   output logic             flush_IFID,
   output logic             bubble_EX,
   output logic             nop_EX,
   output logic             nop_MEM,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [6:0] OP_RRAI = 7'b0110011;
   localparam logic [6:0] OP_RIAI = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_CBI  = 7'b1100011;
   localparam logic [2:0] STALL_EXTRA = 3'(LOAD_STALL_CYCLES - 1);

   typedef enum logic {RUN, STALL} state_t;

   state_t     r_state, w_next_state;
   logic [2:0] r_remain, w_next_remain;

   logic [6:0] w_op_id;
   logic [4:0] w_rd_ex;
   logic       w_rs1_used, w_rs2_used, w_hz;
   logic       w_unused_bits;

   assign w_op_id = inst_ID[6:0];
   assign w_rd_ex = inst_EX[11:7];

   // Source-register usage of the instruction in ID; JAL reads no registers.
   always_comb begin
      w_rs1_used = 1'b0;
      w_rs2_used = 1'b0;
      case (w_op_id)
         OP_RRAI, OP_CBI, OP_SW: begin
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         OP_RIAI, OP_LW, OP_JALR: w_rs1_used = 1'b1;
         OP_JAL:                  w_rs1_used = 1'b0;
         default:                 w_rs1_used = 1'b0;
      endcase
   end

   assign w_hz = valid_EX && (inst_EX[6:0] == OP_LW) && (w_rd_ex != 5'd0) && valid_ID &&
                 ((w_rs1_used && (inst_ID[19:15] == w_rd_ex)) ||
                  (w_rs2_used && (inst_ID[24:20] == w_rd_ex)));

   assign w_unused_bits = ^{inst_ID[31:25], inst_ID[14:7], inst_EX[31:12]};

   // Next-state and control outputs; redirect always beats a pending or new stall.
   always_comb begin
      w_next_state  = r_state;
      w_next_remain = r_remain;
      stall_PC      = 1'b0;
      stall_IFID    = 1'b0;
      flush_IFID    = 1'b0;
      bubble_EX     = 1'b0;
      if (RST) begin
         w_next_state  = RUN;
         w_next_remain = 3'd0;
      end else if (redirect_EX) begin
         flush_IFID    = 1'b1;
         bubble_EX     = 1'b1;
         w_next_state  = RUN;
         w_next_remain = 3'd0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_hz) begin
                  stall_PC   = 1'b1;
                  stall_IFID = 1'b1;
                  bubble_EX  = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     w_next_state  = STALL;
                     w_next_remain = STALL_EXTRA;
                  end
               end
            end
            STALL: begin
               stall_PC   = 1'b1;
               stall_IFID = 1'b1;
               bubble_EX  = 1'b1;
               if (r_remain <= 3'd1) begin
                  w_next_state  = RUN;
                  w_next_remain = 3'd0;
               end else begin
                  w_next_remain = r_remain - 3'd1;
               end
            end
            default: begin
               w_next_state  = RUN;
               w_next_remain = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= RUN;
         r_remain <= 3'd0;
         nop_EX   <= 1'b1;
         nop_MEM  <= 1'b1;
      end else begin
         r_state  <= w_next_state;
         r_remain <= w_next_remain;
         nop_EX   <= bubble_EX;
         nop_MEM  <= nop_EX;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_PC)   r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (flush_IFID) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline control block that issues stalls, bubbles and flushes for the 5-stage RV32I core; the forwarding logic in EX only resolves hazards it can bypass. It detects load-use hazards between ID and EX, holds PC and IF/ID while injecting bubbles into ID/EX, and flushes on taken control transfers from EX. It also generates the registered `nop_EX`/`nop_MEM` flags that the forwarding logic uses to ignore bubbled stages.

## Interface
Parameters:
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use hazard, range 1–7 (1 = MEM→EX forwarding present).
- `CNT_W`, default 32: width of performance counters.

Ports:
- `CLK` in 1: single clock, all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `inst_ID` in 32: instruction in the ID stage.
- `valid_ID` in 1: `inst_ID` is a real instruction.
- `inst_EX` in 32: instruction in the EX stage.
- `valid_EX` in 1: `inst_EX` is a real instruction.
- `redirect_EX` in 1: taken branch, JAL or JALR resolved in EX this cycle.
- `stall_PC` out 1: hold the PC.
- `stall_IFID` out 1: hold the IF/ID register.
- `flush_IFID` out 1: load a NOP into IF/ID.
- `bubble_EX` out 1: load a NOP into ID/EX.
- `nop_EX` out 1: registered; the EX stage holds a bubble.
- `nop_MEM` out 1: registered; the MEM stage holds a bubble.
- `stall_cnt` out `CNT_W`: count of load-use stall cycles.
- `flush_cnt` out `CNT_W`: count of redirect flushes.

## Operation
- Opcodes: RRAI 0110011, RIAI 0010011, LW 0000011, SW 0100011, JAL 1101111, JALR 1100111, CBI 1100011.
- rs1 is used by ID for RIAI, LW, SW, JALR, RRAI and CBI. rs2 is used by ID for RRAI, CBI and SW.
- `hz` = `valid_EX` & `inst_EX[6:0]`==LW & `inst_EX[11:7]`!=0 & `valid_ID` & ((rs1 used & `inst_ID[19:15]`==`inst_EX[11:7]`) | (rs2 used & `inst_ID[24:20]`==`inst_EX[11:7]`)).
- FSM states and counter:
  - RUN, STALL, plus a 3-bit `remain` counter.
  - RUN, `redirect_EX`=1: assert `flush_IFID` and `bubble_EX`; no stall; stay in RUN.
  - RUN, `hz`=1 (no redirect): assert `stall_PC`, `stall_IFID` and `bubble_EX`. If `LOAD_STALL_CYCLES`>1, go to STALL with `remain`=`LOAD_STALL_CYCLES`-1; else stay in RUN.
  - STALL: assert `stall_PC`, `stall_IFID` and `bubble_EX`; decrement `remain`; when `remain`==1, return to RUN next cycle.
  - STALL with `redirect_EX`=1: redirect wins. Assert `flush_IFID` and `bubble_EX`, deassert the stalls, clear `remain`, go to RUN.
- Redirect has priority over `hz` in every state; `stall_*` and `flush_IFID` are never asserted together.
- `nop_EX` <= `bubble_EX`. `nop_MEM` <= `nop_EX`.
- `stall_cnt` increments in every cycle where `stall_PC`=1. `flush_cnt` increments in every cycle where `flush_IFID`=1. Both wrap modulo 2^`CNT_W`.

## Timing
- `stall_PC`, `stall_IFID`, `flush_IFID` and `bubble_EX` are combinational from the inputs and state, valid in the same cycle as the hazard.
- Load-use penalty is exactly `LOAD_STALL_CYCLES` cycles. The dependent instruction enters EX on the cycle after the last bubble.
- `nop_EX` lags `bubble_EX` by 1 cycle; `nop_MEM` lags it by 2 cycles.
- While `RST`=1: all combinational outputs are forced to 0, state=RUN, `remain`=0, `nop_EX`=1, `nop_MEM`=1, both counters=0.
- Reset asserted mid-STALL: takes effect on the next edge and drops the stall outright; there is no residual bubble.
- A hazard that reappears in the cycle STALL returns to RUN (a new load in EX) is detected in RUN as normal.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cnt` and `flush_cnt` are implemented as above.
- `HAZARD_PERF_CNT_EN` undefined: the counter registers are not built, and `stall_cnt`/`flush_cnt` are tied to 0.

## Test plan
- Load-use on rs1: `lw x5,0(x1)` in EX, `add x6,x5,x2` in ID, `LOAD_STALL_CYCLES`=1 -> `stall_PC`=`stall_IFID`=`bubble_EX`=1 for exactly 1 cycle; `nop_EX`=1 the next cycle; `nop_MEM`=1 the cycle after; `stall_cnt`=1.
- SW data on rs2: `lw x7` in EX, `sw x7,4(x3)` in ID -> stall asserted. `lw x0` in EX with `add x1,x0,x0` in ID -> no stall.
- Multi-cycle stall: `LOAD_STALL_CYCLES`=3 with a load-use pair -> stall held exactly 3 cycles; `stall_cnt`=3; RUN on cycle 4.
- Redirect priority: `LOAD_STALL_CYCLES`=3; `redirect_EX`=1 in the second STALL cycle -> `flush_IFID`=`bubble_EX`=1, `stall_PC`=0 that cycle; RUN next cycle; `flush_cnt`=1.
- Reset mid-stall: `RST`=1 during STALL -> the next cycle all outputs are 0 except `nop_EX`=`nop_MEM`=1, counters 0; the pipeline resumes cleanly after `RST`=0.
- Build without `HAZARD_PERF_CNT_EN`: repeat the load-use test -> `stall_cnt`=`flush_cnt`=0 throughout; stall behaviour identical.
